robohand: RTL and testbench

ROBOHAND -- requirements
Module: robohand

---
 rtl/robohand.sv | 168 ++++++++++++++++
 tb/tb_robohand.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/robohand.sv
// Robot opponent paddle: follows the ball on ball-clock ticks with a reaction delay, deadzone and step limit.
// Optional build macro ROBOHAND_JITTER_EN adds an LFSR-derived aim offset latched on each entry to tracking.
module robohand #(
  parameter logic [9:0] SCREENHEIGHT = 10'd480,
  parameter logic [9:0] PADDLESIZE   = 10'd64,
  parameter int         STEP         = 2,
  parameter int         DEADZONE     = 4,
  parameter int         REACTION     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ballAdvance,
  input  logic [9:0] ball_y,
  input  logic       engage,
  output logic [9:0] paddle_y,
  output logic       moving
);

  localparam logic [9:0]  HALF   = PADDLESIZE >> 1;
  localparam logic [9:0]  LO     = HALF;
  localparam logic [9:0]  HI     = SCREENHEIGHT - 10'd1 - HALF;
  localparam logic [9:0]  CENTRE = SCREENHEIGHT >> 1;
  localparam logic [9:0]  STEP_L = 10'(STEP);
  localparam logic [9:0]  DEAD_L = 10'(DEADZONE);
  localparam logic [15:0] RELOAD = 16'(REACTION);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    TRACK = 3'd2,
    HOME  = 3'd3
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [9:0]  paddle_next;
  logic [9:0]  target;
  logic [11:0] ball_adj;
  logic [3:0]  jitter_off;

  logic       sync1, sync2, prev;
  logic [1:0] fill_cnt;
  logic       armed;
  logic       tick;

  // armed only sets once the synchronizer has seen the ball clock low, so a level high at reset release is not a tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      fill_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      sync1 <= ballAdvance;
      sync2 <= sync1;
      prev  <= sync2;
      if (fill_cnt != 2'd2)
        fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd2 && !sync2)
        armed <= 1'b1;
    end
  end

  assign tick = armed & sync2 & ~prev;

`ifdef ROBOHAND_JITTER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr       <= 8'h01;
      jitter_off <= 4'd0;
    end else begin
      if (tick)
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (state == WAIT && state_next == TRACK)
        jitter_off <= lfsr[3:0];
    end
  end
`else
  assign jitter_off = 4'd0;
`endif

  // 12-bit arithmetic keeps a negative jittered ball_y or one beyond the screen from wrapping
  always_comb begin
    ball_adj = {2'b00, ball_y} + {{8{jitter_off[3]}}, jitter_off};
    if (ball_adj[11] || ball_adj < {2'b00, LO})
      target = LO;
    else if (ball_adj > {2'b00, HI})
      target = HI;
    else
      target = ball_adj[9:0];
  end

  function automatic logic [9:0] step_toward(input logic [9:0] cur,
                                             input logic [9:0] goal,
                                             input logic [9:0] dz);
    logic [10:0] diff;
    logic [9:0]  mag;
    logic [9:0]  amt;
    diff = {1'b0, goal} - {1'b0, cur};
    mag  = diff[10] ? 10'(11'd0 - diff) : diff[9:0];
    amt  = (mag < STEP_L) ? mag : STEP_L;
    if (mag <= dz)
      return cur;
    else if (diff[10])
      return cur - amt;
    else
      return cur + amt;
  endfunction

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    paddle_next = paddle_y;
    case (state)
      IDLE: begin
        if (engage) begin
          state_next = WAIT;
          cnt_next   = RELOAD;
        end
      end
      WAIT: begin
        if (!engage)
          state_next = HOME;
        else if (tick) begin
          if (cnt == 16'd0)
            state_next = TRACK;
          else
            cnt_next = cnt - 16'd1;
        end
      end
      TRACK: begin
        if (!engage)
          state_next = HOME;
        else if (tick)
          paddle_next = step_toward(paddle_y, target, DEAD_L);
      end
      HOME: begin
        if (engage) begin
          state_next = WAIT;
          cnt_next   = RELOAD;
        end else if (tick) begin
          paddle_next = step_toward(paddle_y, CENTRE, 10'd0);
          if (paddle_next == CENTRE)
            state_next = IDLE;
        end
      end
      default: state_next = HOME;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      paddle_y <= CENTRE;
      moving   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      paddle_y <= paddle_next;
      moving   <= (paddle_next != paddle_y);
    end
  end

endmodule

// File: tb/tb_robohand.sv
// Scoreboard bench for robohand: stimulus queues expected paddle positions, a monitor pops one per moving pulse.
module tb_robohand;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ballAdvance = 1'b0;
  logic [9:0] ball_y = 10'd0;
  logic       engage = 1'b0;
  logic [9:0] paddle_y;
  logic       moving;

  int checks = 0;
  int errors = 0;
  logic [9:0] expQ[$];

  always #5 clk = ~clk;

  robohand dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ballAdvance(ballAdvance),
    .ball_y     (ball_y),
    .engage     (engage),
    .paddle_y   (paddle_y),
    .moving     (moving)
  );

  task automatic checkOutput(input string name, input logic [9:0] actual, input logic [9:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One full ball-clock period; called on a negedge, returns on a negedge with any move already applied
  task automatic applyStimulus(input logic [9:0] by, input logic expMove, input logic [9:0] expY);
    if (expMove)
      expQ.push_back(expY);
    ball_y = by;
    ballAdvance = 1'b1;
    repeat (4) @(negedge clk);
    ballAdvance = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic moveRun(input logic [9:0] by, input int first, input int last, input int dir);
    for (int v = first; (dir > 0) ? (v <= last) : (v >= last); v += 2 * dir)
      applyStimulus(by, 1'b1, 10'(v));
  endtask

  task automatic holdTicks(input string name, input logic [9:0] by, input int n, input logic [9:0] holdY);
    for (int i = 0; i < n; i++) begin
      applyStimulus(by, 1'b0, 10'd0);
      checkOutput(name, paddle_y, holdY);
    end
  endtask

  initial begin
    logic [9:0] expY;
    forever begin
      @(negedge clk);
      if (reset_n && moving) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_move: got move to %0d expected no move", paddle_y);
        end else begin
          expY = expQ.pop_front();
          if (paddle_y !== expY) begin
            errors++;
            $display("[TB] FAIL move_value: got %0d expected %0d", paddle_y, expY);
          end
        end
      end
    end
  end

  initial begin
    // Reset with the ball clock already high and engage set: no phantom tick may eat a reaction count
    ballAdvance = 1'b1;
    engage = 1'b1;
    ball_y = 10'd400;
    #3 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_paddle", paddle_y, 10'd240);
    checkOutput("reset_moving", {9'd0, moving}, 10'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("release_high_hold", paddle_y, 10'd240);
    ballAdvance = 1'b0;
    repeat (4) @(negedge clk);

    holdTicks("reaction_hold", 10'd400, 9, 10'd240);
    applyStimulus(10'd400, 1'b1, 10'd242);
    checkOutput("first_move", paddle_y, 10'd242);
    moveRun(10'd400, 244, 396, 1);
    holdTicks("deadzone_hold", 10'd400, 3, 10'd396);

    moveRun(10'd0, 394, 36, -1);
    holdTicks("floor_hold", 10'd0, 3, 10'd36);

    moveRun(10'd1023, 38, 444, 1);
    holdTicks("ceiling_hold", 10'd1023, 3, 10'd444);

    // Drop engage, home a few steps, then re-engage: reaction delay restarts from the full count
    engage = 1'b0;
    repeat (2) @(negedge clk);
    moveRun(10'd1023, 442, 438, -1);
    engage = 1'b1;
    repeat (2) @(negedge clk);
    holdTicks("reengage_hold", 10'd1023, 9, 10'd438);
    applyStimulus(10'd1023, 1'b1, 10'd440);
    checkOutput("reengage_move", paddle_y, 10'd440);
    moveRun(10'd1023, 442, 444, 1);
    holdTicks("ceiling_hold2", 10'd1023, 2, 10'd444);

    engage = 1'b0;
    repeat (2) @(negedge clk);
    moveRun(10'd1023, 442, 240, -1);
    checkOutput("home_reached", paddle_y, 10'd240);
    holdTicks("idle_hold", 10'd1023, 2, 10'd240);

    engage = 1'b1;
    repeat (2) @(negedge clk);
    holdTicks("idle_engage_hold", 10'd1023, 9, 10'd240);
    moveRun(10'd1023, 242, 246, 1);

    // Reset lands while a tick is pending; the step must be dropped
    ball_y = 10'd1023;
    ballAdvance = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midmove_reset_paddle", paddle_y, 10'd240);
    checkOutput("midmove_reset_moving", {9'd0, moving}, 10'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    ballAdvance = 1'b0;
    repeat (4) @(negedge clk);
    holdTicks("post_reset_hold", 10'd1023, 9, 10'd240);
    applyStimulus(10'd1023, 1'b1, 10'd242);
    checkOutput("post_reset_move", paddle_y, 10'd242);

    repeat (4) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL missed_moves: got %0d pending expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
